// File: rtl/mips_imem_loader_if.sv
// Host byte link + imem write port + core control bundle for the imem loader.
interface mips_imem_loader_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              core_hold;
  logic              done;
  logic              error;

  modport master (
    output start, rx_valid, rx_data,
    input  rx_ready, wr_en, wr_addr, wr_data, core_hold, done, error
  );

  modport slave (
    input  start, rx_valid, rx_data,
    output rx_ready, wr_en, wr_addr, wr_data, core_hold, done, error
  );
endinterface

// File: rtl/mips_imem_loader.sv
// Instruction-ROM writer: parses A5/LEN/DATA/CSUM frames from the host byte link,
// packs big-endian words into imem at 0..N-1 and releases the core once the
// frame checksum matches.
module mips_imem_loader #(
  parameter int ADDR_L = 64,
  parameter int ADDR_W = $clog2(ADDR_L)
) (
  input  logic clk_i,
  input  logic rst_ni,
  mips_imem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        csum_q, csum_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              rdy_q, hold_q, done_q, err_q;

  logic              xfer;
  logic [15:0]       n_len;
  logic [ADDR_W-1:0] last_addr;

  // start blocks the handshake so a byte offered alongside it is never consumed
  assign xfer      = bus.rx_valid & rdy_q & ~bus.start;
  assign n_len     = {len_q[15:8], bus.rx_data};
  assign last_addr = ADDR_W'(len_q - 16'd1);

  assign bus.rx_ready  = rdy_q & ~bus.start;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.core_hold = hold_q;
  assign bus.done      = done_q;
  assign bus.error     = err_q;

  // next-state: frame parser, word packer and checksum accumulator
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    addr_d    = addr_q;
    bidx_d    = bidx_q;
    word_d    = word_q;
    csum_d    = csum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (bus.start) begin
      state_d = S_IDLE;
      addr_d  = '0;
      bidx_d  = '0;
      csum_d  = '0;
    end else if (xfer) begin
      unique case (state_q)
        S_IDLE:   if (bus.rx_data == 8'hA5) state_d = S_LEN_HI;
        S_LEN_HI: begin
          len_d[15:8] = bus.rx_data;
          state_d     = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d  = n_len;
          addr_d = '0;
          bidx_d = '0;
          csum_d = '0;
          if (n_len > 16'(ADDR_L))   state_d = S_ERROR;
          else if (n_len == 16'd0)   state_d = S_CHECK;
          else                       state_d = S_DATA;
        end
        S_DATA: begin
          word_d = {word_q[23:0], bus.rx_data};
          csum_d = csum_q ^ bus.rx_data;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = {word_q[23:0], bus.rx_data};
            addr_d    = addr_q + ADDR_W'(1);
            if (addr_q == last_addr) state_d = S_CHECK;
          end
        end
        S_CHECK:  state_d = (bus.rx_data == csum_q) ? S_DONE : S_ERROR;
        default:  state_d = state_q;
      endcase
    end
  end

  // state, datapath and registered status outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      addr_q    <= '0;
      bidx_q    <= '0;
      word_q    <= '0;
      csum_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rdy_q     <= 1'b1;
      hold_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      bidx_q    <= bidx_d;
      word_q    <= word_d;
      csum_q    <= csum_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rdy_q     <= (state_d != S_DONE) && (state_d != S_ERROR);
      hold_q    <= (state_d != S_DONE);
      done_q    <= (state_d == S_DONE);
      err_q     <= (state_d == S_ERROR);
    end
  end

endmodule
